// File: rtl/inst_queue_pkg.sv
// Shared instruction-queue definitions: issue verdict encodings, instruction bus width, entry type.
// The macros stand in for the shared defines header and are guarded so an existing copy wins.
`ifndef INST_BUS
`define INST_BUS [31:0]
`endif
`ifndef SINGLE_ISSUE
`define SINGLE_ISSUE 1'b0
`endif
`ifndef DUAL_ISSUE
`define DUAL_ISSUE 1'b1
`endif

package inst_queue_pkg;

   localparam logic SingleIssue = `SINGLE_ISSUE;
   localparam logic DualIssue   = `DUAL_ISSUE;

   typedef struct packed {
      logic `INST_BUS inst;
      logic [31:0]    pc;
   } entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// Fetch-side push, issue-side pop and flush signals of the instruction queue.
interface inst_queue_if;
   import inst_queue_pkg::*;

   logic           flush;
   logic           in_valid1;
   logic           in_valid2;
   logic `INST_BUS in_inst1;
   logic `INST_BUS in_inst2;
   logic [31:0]    in_pc1;
   logic [31:0]    in_pc2;
   logic           in_ready;
   logic           id_allowin;
   logic           issue_mode;
   logic           out_valid1;
   logic           out_valid2;
   logic `INST_BUS out_inst1;
   logic `INST_BUS out_inst2;
   logic [31:0]    out_pc1;
   logic [31:0]    out_pc2;

   modport master (
      output flush, in_valid1, in_valid2, in_inst1, in_inst2, in_pc1, in_pc2,
      output id_allowin, issue_mode,
      input  in_ready, out_valid1, out_valid2, out_inst1, out_inst2, out_pc1, out_pc2
   );

   modport slave (
      input  flush, in_valid1, in_valid2, in_inst1, in_inst2, in_pc1, in_pc2,
      input  id_allowin, issue_mode,
      output in_ready, out_valid1, out_valid2, out_inst1, out_inst2, out_pc1, out_pc2
   );

endinterface

// File: rtl/inst_queue.sv
// Dual-slot instruction queue between fetch and decode: circular buffer, up to two pushes and
// two pops per cycle, validity derived only from the registered count.
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input logic         clk,
   input logic         resetn,
   inst_queue_if.slave q
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   // Room for a full two-instruction push is guaranteed at or below this count.
   localparam logic [CntW-1:0] ReadyMax = CntW'(DEPTH - 2);

   entry_t          mem [DEPTH];
   logic [PtrW-1:0] head_q, head_d, head_p1;
   logic [PtrW-1:0] tail_q, tail_d, tail_p1;
   logic [CntW-1:0] count_q, count_d;
   logic [1:0]      push_n, pop_n;
   logic            ready, valid1, valid2;

   always_comb begin
      head_p1 = head_q + PtrW'(1);
      tail_p1 = tail_q + PtrW'(1);
      ready   = (count_q <= ReadyMax);
      valid1  = (count_q >= CntW'(1));
      valid2  = (count_q >= CntW'(2));

      push_n = 2'd0;
      if (ready && q.in_valid1) begin
         push_n = q.in_valid2 ? 2'd2 : 2'd1;
      end

      pop_n = 2'd0;
      if (q.id_allowin && valid1) begin
         pop_n = (q.issue_mode == `DUAL_ISSUE && valid2) ? 2'd2 : 2'd1;
      end

      head_d  = head_q + PtrW'(pop_n);
      tail_d  = tail_q + PtrW'(push_n);
      count_d = count_q + CntW'(push_n) - CntW'(pop_n);
      if (q.flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage is deliberately unreset; stale entries are never visible because count gates them.
   always_ff @(posedge clk) begin
      if (!q.flush && push_n != 2'd0) begin
         mem[tail_q] <= '{inst: q.in_inst1, pc: q.in_pc1};
      end
      if (!q.flush && push_n == 2'd2) begin
         mem[tail_p1] <= '{inst: q.in_inst2, pc: q.in_pc2};
      end
   end

   always_comb begin
      q.in_ready   = ready;
      q.out_valid1 = valid1;
      q.out_valid2 = valid2;
      q.out_inst1  = valid1 ? mem[head_q].inst : '0;
      q.out_pc1    = valid1 ? mem[head_q].pc : '0;
      q.out_inst2  = valid2 ? mem[head_p1].inst : '0;
      q.out_pc2    = valid2 ? mem[head_p1].pc : '0;
   end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus randomized push/pop/flush traffic
// compared against a queue-based reference model.
module tb_inst_queue;
   import inst_queue_pkg::*;

   localparam int unsigned DEPTH = 8;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   n_assert = 0;
   int   n_fail = 0;

   logic [31:0] m_inst[$];
   logic [31:0] m_pc[$];
   logic [31:0] next_pc;

   inst_queue_if iq ();

   inst_queue #(.DEPTH(DEPTH)) dut (
      .clk    (clk),
      .resetn (resetn),
      .q      (iq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string ctx);
      int n;
      n = m_inst.size();
      chk({ctx, " in_ready"}, 32'(iq.in_ready), 32'(n <= int'(DEPTH) - 2));
      chk({ctx, " out_valid1"}, 32'(iq.out_valid1), 32'(n >= 1));
      chk({ctx, " out_valid2"}, 32'(iq.out_valid2), 32'(n >= 2));
      chk({ctx, " out_inst1"}, iq.out_inst1, (n >= 1) ? m_inst[0] : 32'h0);
      chk({ctx, " out_pc1"}, iq.out_pc1, (n >= 1) ? m_pc[0] : 32'h0);
      chk({ctx, " out_inst2"}, iq.out_inst2, (n >= 2) ? m_inst[1] : 32'h0);
      chk({ctx, " out_pc2"}, iq.out_pc2, (n >= 2) ? m_pc[1] : 32'h0);
   endtask

   // Reference behaviour for one clock edge, from the currently driven inputs.
   task automatic model_edge(output int pushed);
      int  n;
      int  npop;
      bit  rdy;
      n      = m_inst.size();
      rdy    = (n <= int'(DEPTH) - 2);
      pushed = 0;
      if (iq.flush) begin
         m_inst.delete();
         m_pc.delete();
         return;
      end
      npop = 0;
      if (iq.id_allowin && n >= 1) npop = (iq.issue_mode == DualIssue && n >= 2) ? 2 : 1;
      repeat (npop) begin
         void'(m_inst.pop_front());
         void'(m_pc.pop_front());
      end
      if (rdy && iq.in_valid1) begin
         m_inst.push_back(iq.in_inst1);
         m_pc.push_back(iq.in_pc1);
         pushed = 1;
         if (iq.in_valid2) begin
            m_inst.push_back(iq.in_inst2);
            m_pc.push_back(iq.in_pc2);
            pushed = 2;
         end
      end
   endtask

   task automatic drive(input logic v1, input logic v2, input logic [31:0] i1, input logic [31:0] p1,
                        input logic [31:0] i2, input logic [31:0] p2, input logic allow,
                        input logic mode, input logic fl);
      iq.in_valid1  = v1;
      iq.in_valid2  = v2;
      iq.in_inst1   = i1;
      iq.in_pc1     = p1;
      iq.in_inst2   = i2;
      iq.in_pc2     = p2;
      iq.id_allowin = allow;
      iq.issue_mode = mode;
      iq.flush      = fl;
   endtask

   task automatic step(input string ctx, output int pushed);
      @(negedge clk);
      check_outputs(ctx);
      model_edge(pushed);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input string ctx, input logic allow, input logic mode);
      int p;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, allow, mode, 1'b0);
      step(ctx, p);
   endtask

   // Fetch presents sequential PCs and only advances once the queue has accepted them.
   task automatic fetch(input string ctx, input logic v1, input logic v2, input logic allow,
                        input logic mode, input logic fl);
      int p;
      drive(v1, v1 & v2, $urandom, next_pc, $urandom, next_pc + 32'd4, allow, mode, fl);
      step(ctx, p);
      next_pc = next_pc + 32'(4 * p);
   endtask

   initial begin
      int p;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, SingleIssue, 1'b0);
      #1;
      check_outputs("reset");
      @(posedge clk);
      #1;
      resetn = 1'b1;

      // Dual push then dual pop of the boot pair.
      drive(1'b1, 1'b1, 32'h00221820, 32'hBFC00000, 32'h00853020, 32'hBFC00004,
            1'b1, DualIssue, 1'b0);
      step("boot_push", p);
      idle("boot_pop", 1'b1, DualIssue);
      idle("boot_empty", 1'b1, DualIssue);

      // Fill to 7 with decode stalled; the next push must be dropped.
      next_pc = 32'h0000_1000;
      fetch("fill1", 1'b1, 1'b0, 1'b0, SingleIssue, 1'b0);
      repeat (3) fetch("fill2", 1'b1, 1'b1, 1'b0, SingleIssue, 1'b0);
      fetch("full_drop", 1'b1, 1'b1, 1'b0, SingleIssue, 1'b0);
      repeat (8) idle("drain", 1'b1, SingleIssue);

      // count=5 with push 2 and single pop -> 6.
      fetch("c5_a", 1'b1, 1'b0, 1'b0, SingleIssue, 1'b0);
      repeat (2) fetch("c5_b", 1'b1, 1'b1, 1'b0, SingleIssue, 1'b0);
      fetch("push_pop", 1'b1, 1'b1, 1'b1, SingleIssue, 1'b0);
      idle("c6", 1'b0, SingleIssue);
      repeat (4) idle("drain2", 1'b1, DualIssue);

      // Single entry with a dual verdict pops only one.
      fetch("one", 1'b1, 1'b0, 1'b0, DualIssue, 1'b0);
      idle("one_dual", 1'b1, DualIssue);
      idle("one_empty", 1'b1, DualIssue);

      // Randomized mixed traffic, wrapping the pointers many times.
      for (int i = 0; i < 200; i++) begin
         fetch("rand", 1'($urandom), 1'($urandom), 1'($urandom_range(3) != 0), 1'($urandom),
               1'($urandom_range(15) == 0));
      end
      repeat (5) idle("rand_drain", 1'b1, DualIssue);

      // Flush at count=4 with a simultaneous push and pop request.
      repeat (2) fetch("pre_flush", 1'b1, 1'b1, 1'b0, SingleIssue, 1'b0);
      fetch("flush", 1'b1, 1'b1, 1'b1, DualIssue, 1'b1);
      idle("post_flush", 1'b0, SingleIssue);

      // Asynchronous reset mid-stream.
      repeat (2) fetch("pre_rst", 1'b1, 1'b1, 1'b0, SingleIssue, 1'b0);
      drive(1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, DualIssue, 1'b0);
      @(negedge clk);
      #2;
      resetn = 1'b0;
      #1;
      m_inst.delete();
      m_pc.delete();
      check_outputs("async_rst");
      drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, SingleIssue, 1'b0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      fetch("post_rst", 1'b1, 1'b1, 1'b0, SingleIssue, 1'b0);
      idle("post_rst_pop", 1'b1, SingleIssue);
      idle("post_rst_end", 1'b1, SingleIssue);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter DEPTH, default 8, means queue capacity in instructions; power of two, >= 4.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  discard all queued instructions (branch/exception redirect).
REQ-005 in_valid1  input  1  fetch slot 1 carries an instruction.
REQ-006 in_valid2  input  1  fetch slot 2 carries an instruction; legal only with in_valid1=1.
REQ-007 in_inst1, in_inst2  input  `INST_BUS  fetched instruction words, program order slot1 then slot2.
REQ-008 in_pc1, in_pc2  input  32  PCs of the fetched instructions.
REQ-009 in_ready  output  1  queue accepts a two-instruction push this cycle.
REQ-010 id_allowin  input  1  decode/issue stage can take instructions this cycle.
REQ-011 issue_mode  input  1  `SINGLE_ISSUE or `DUAL_ISSUE verdict from the issue checker for out_inst1/out_inst2.
REQ-012 out_valid1, out_valid2  output  1  head and head+1 entries are valid.
REQ-013 out_inst1, out_inst2  output  `INST_BUS  instructions at head and head+1; feed the issue checker inst1/inst2.
REQ-014 out_pc1, out_pc2  output  32  PCs of those instructions.

Function
REQ-015 Storage: circular buffer of DEPTH entries {inst, pc}, head pointer, tail pointer, count of log2(DEPTH)+1 bits.
REQ-016 Pointers wrap modulo DEPTH; head+1 read wraps from DEPTH-1 to 0.
REQ-017 in_ready = (count <= DEPTH-2), computed from registered count only.
REQ-018 Push count = in_ready ? (in_valid1 + (in_valid1 & in_valid2)) : 0; slot1 written at tail, slot2 at tail+1.
REQ-019 Push with in_ready=0 is dropped; fetch holds its data.
REQ-020 out_valid1 = (count >= 1); out_valid2 = (count >= 2); outputs read combinationally from registered entries.
REQ-021 Invalid output slots drive inst and pc as zero.
REQ-022 Pop count = 0 if id_allowin=0 or out_valid1=0; 2 if issue_mode=`DUAL_ISSUE and out_valid2=1; else 1.
REQ-023 Latency: instruction pushed in cycle N visible at outputs in cycle N+1 earliest; no bypass from inputs to outputs.
REQ-024 Simultaneous push and pop in one cycle: count_next = count + push - pop; no overflow possible given REQ-017.
REQ-025 flush=1: head, tail, count cleared next edge; same-cycle push and pop ignored.
REQ-026 Program order preserved: out_inst1 always older than out_inst2.
REQ-027 Entry contents need not be cleared on pop or flush; validity derives solely from count.

Reset
REQ-028 resetn=0 asynchronously clears head, tail, count to 0; out_valid1/2=0, out_inst*/out_pc*=0, in_ready=1.
REQ-029 Entry storage is not reset.
REQ-030 Reset asserted mid-push or mid-pop discards that transfer; first post-reset push lands at entry 0.

Structure
REQ-031 `SINGLE_ISSUE, `DUAL_ISSUE, `INST_BUS come from the shared defines.v; no local redefinition.
REQ-032 DEPTH-derived pointer width computed locally with $clog2.
REQ-033 Single flat module; no sub-modules.

Verification
REQ-034 Reset, push {0x00221820@0xBFC00000, 0x00853020@0xBFC00004}, id_allowin=1, DUAL -> next cycle out_valid1/2=1 with those words; following cycle count=0.
REQ-035 Fill with id_allowin=0 -> in_ready falls when count=7 (DEPTH=8); push then dropped; drain shows exactly 7 instructions in order.
REQ-036 count=5, push 2 and SINGLE pop same cycle -> count=6; head advances by 1.
REQ-037 count=1, issue_mode=DUAL -> pop 1 only; out_valid2=0, out_inst2=0.
REQ-038 Pointer wrap: 20 push/pop cycles of mixed single/dual at DEPTH=8 -> output PC sequence strictly +4 contiguous, no loss or duplication.
REQ-039 flush with simultaneous push and count=4 -> next cycle count=0, out_valid1=0, in_ready=1; resetn pulse mid-stream -> immediate out_valid1=0.
